fft_output_reorder: RTL and testbench

Downstream of the final two-point butterfly stage of the 16-point FFT. Collects the eight stage-4 butterfly result pairs, which arrive in bit-reversed position order and in any pair order. Writes each pair into a 16-entry frame buffer at its natural-order index, then streams the frame out in natural order X[0]..X[15], one sample per cycle under valid/ready. The buffer is ping-pong (two banks), so the next frame can be collected while the current one drains.

---
 rtl/fft_output_reorder_pkg.sv | 19 +
 rtl/fft_output_reorder_if.sv | 31 +++
 rtl/fft_output_reorder_bank.sv | 32 +++
 rtl/fft_output_reorder.sv | 98 +++++++++
 tb/tb_fft_output_reorder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_output_reorder_pkg.sv
// Shared constants, sample type and bit-reversal helper for the 16-point FFT
// output reorder path.
package fft_pkg;

  localparam int unsigned DW    = 32;
  localparam int unsigned N     = 16;
  localparam int unsigned LOG2N = 4;
  localparam int unsigned PAIRS = N / 2;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } sample_t;

  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

endpackage

// File: rtl/fft_output_reorder_if.sv
// Handshake bundle for fft_output_reorder.
//   in_valid/in_ready/in_pair/in_d0/in_d1 : butterfly pair input
//   out_valid/out_ready/out_data/out_idx/out_last : natural-order stream
//   dup_err : pulse on a repeated pair index within one frame
// slave = the reorder block, master = its environment.
interface fft_output_reorder_if;
  import fft_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_pair;
  logic [DW-1:0]        in_d0;
  logic [DW-1:0]        in_d1;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [LOG2N-1:0]     out_idx;
  logic                 out_last;
  logic                 dup_err;

  modport slave (
    input  in_valid, in_pair, in_d0, in_d1, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, dup_err
  );

  modport master (
    output in_valid, in_pair, in_d0, in_d1, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, dup_err
  );

endinterface

// File: rtl/fft_output_reorder_bank.sv
// One 16-sample frame bank: two-address write (a whole butterfly pair per
// cycle) and one combinational read port.
//   clk      : clock
//   we       : write both addresses this edge
//   wa0/wd0  : first write address/data
//   wa1/wd1  : second write address/data
//   ra/rd    : read address / combinational read data
module fft_reorder_bank
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] wa0,
  input  logic [LOG2N-1:0] wa1,
  input  sample_t          wd0,
  input  sample_t          wd1,
  input  logic [LOG2N-1:0] ra,
  output sample_t          rd
);

  sample_t mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa0] <= wd0;
      mem[wa1] <= wd1;
    end
  end

  assign rd = mem[ra];

endmodule

// File: rtl/fft_output_reorder.sv
// Collects the eight final-stage butterfly pairs of a 16-point FFT (bit-
// reversed positions, any pair order) into a ping-pong frame buffer and
// streams each frame out in natural order X[0]..X[15].
//   clk  : clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : pair input, natural-order output stream and dup_err (slave side)
module fft_output_reorder
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fft_output_reorder_if.slave bus
);

  logic             wr_bank;
  logic             rd_bank;
  logic [1:0]       full;
  logic [PAIRS-1:0] pair_mask;
  logic [LOG2N-1:0] rd_cnt;
  logic             dup_err_q;

  logic             accept;
  logic             complete;
  logic             rd_fire;
  logic             rd_done;
  logic [PAIRS-1:0] mask_set;
  logic [LOG2N-1:0] wa0;
  logic [LOG2N-1:0] wa1;
  logic [1:0]       we;
  sample_t          rd_data [2];

  always_comb begin
    accept   = bus.in_valid & ~full[wr_bank];
    mask_set = pair_mask | (PAIRS'(1) << bus.in_pair);
    complete = accept & (&mask_set);
    rd_fire  = full[rd_bank] & bus.out_ready;
    rd_done  = rd_fire & (rd_cnt == LOG2N'(N - 1));
    // Position 2k has bit 0 clear, so its reversed index has bit 3 clear
    // and the partner position 2k+1 lands exactly 8 entries higher.
    wa0      = bitrev4({bus.in_pair, 1'b0});
    wa1      = {1'b1, wa0[2:0]};
    // Writes are held off during reset so a frame never starts there.
    we[0]    = accept & rst & ~wr_bank;
    we[1]    = accept & rst & wr_bank;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank u_bank (
      .clk (clk),
      .we  (we[b]),
      .wa0 (wa0),
      .wa1 (wa1),
      .wd0 (bus.in_d0),
      .wd1 (bus.in_d1),
      .ra  (rd_cnt),
      .rd  (rd_data[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      pair_mask <= '0;
      rd_cnt    <= '0;
      dup_err_q <= 1'b0;
    end else begin
      dup_err_q <= accept & pair_mask[bus.in_pair];
      if (accept) begin
        if (complete) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          pair_mask     <= '0;
        end else begin
          pair_mask <= mask_set;
        end
      end
      // A completing write and a finishing drain always target different
      // banks, so both full-bit updates can land on the same edge.
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_done) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

  assign bus.in_ready  = ~full[wr_bank];
  assign bus.out_valid = full[rd_bank];
  assign bus.out_data  = full[rd_bank] ? rd_data[rd_bank] : '0;
  assign bus.out_idx   = rd_cnt;
  assign bus.out_last  = full[rd_bank] & (rd_cnt == LOG2N'(N - 1));
  assign bus.dup_err   = dup_err_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Self-checking bench for fft_output_reorder: a sample-queue model of the
// ping-pong reorder buffer compared every cycle, plus directed scenarios
// with literal expectations.
module tb_fft_output_reorder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_output_reorder_if bus ();

  fft_output_reorder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: natural-order samples of completed frames, waiting to be output.
  logic [31:0] exp_q [$];
  logic [31:0] cur [16];
  logic [7:0]  mask = '0;
  int          pos = 0;
  logic        dup_e = 1'b0;

  int last_cyc = 0;
  int acc_cyc = -1;

  int ord_inc [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int ord_scr [8] = '{7, 3, 5, 0, 6, 1, 4, 2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rev4(input int x);
    int r = 0;
    for (int b = 0; b < 4; b++)
      if ((x >> b) & 1) r = r | (1 << (3 - b));
    return r;
  endfunction

  function automatic int frames_held();
    return (exp_q.size() + 15) / 16;
  endfunction

  always @(posedge clk) begin : model
    bit rdy_m, acc, fire;
    int k;
    cyc++;
    if (!rst) begin
      exp_q.delete();
      mask  = '0;
      pos   = 0;
      dup_e = 1'b0;
    end else begin
      k     = int'(bus.in_pair);
      rdy_m = frames_held() < 2;
      acc   = bus.in_valid && rdy_m;
      fire  = exp_q.size() > 0 && bus.out_ready;
      dup_e = acc && mask[k];
      if (fire) begin
        void'(exp_q.pop_front());
        pos = (pos + 1) % 16;
      end
      if (acc) begin
        cur[rev4(2 * k)]     = bus.in_d0;
        cur[rev4(2 * k) + 8] = bus.in_d1;
        mask[k] = 1'b1;
        if (mask == 8'hFF) begin
          for (int i = 0; i < 16; i++) exp_q.push_back(cur[i]);
          mask = '0;
        end
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin : compare
    bit v;
    if (chk_en) begin
      v = exp_q.size() > 0;
      check("in_ready", bus.in_ready, frames_held() < 2);
      check("out_valid", bus.out_valid, v);
      check("out_data", bus.out_data, v ? exp_q[0] : 32'h0);
      check("out_idx", bus.out_idx, pos);
      check("out_last", bus.out_last, v && pos == 15);
      check("dup_err", bus.dup_err, dup_e);
      if (bus.out_valid && bus.out_ready && bus.out_last && last_cyc < 0)
        last_cyc = cyc;
    end
  end

  task automatic send_pair(input int k, input logic [31:0] d0, input logic [31:0] d1);
    bit got = 1'b0;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_pair  = 3'(k);
    bus.in_d0    = d0;
    bus.in_d1    = d1;
    while (!got && n < 200) begin
      got = bus.in_ready;
      if (got) acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check("pair_accept_timeout", got, 1'b1);
  endtask

  task automatic send_frame(input int ord [8], input logic [31:0] base);
    int k;
    for (int i = 0; i < 8; i++) begin
      k = ord[i];
      send_pair(k, base + 32'(rev4(2 * k)), base + 32'(rev4(2 * k) + 8));
    end
  endtask

  task automatic expect_ramp();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("ramp_data", bus.out_data, 32'(i));
      check("ramp_idx", bus.out_idx, 32'(i));
      check("ramp_last", bus.out_last, i == 15);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    int nl;
    bit seen2;
    bus.in_valid  = 1'b1;
    bus.in_pair   = 3'd0;
    bus.in_d0     = 32'hDEAD_0000;
    bus.in_d1     = 32'hDEAD_0008;
    bus.out_ready = 1'b1;

    // 1: reset with in_valid held high
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data", bus.out_data, 32'h0);
      check("rst_dup_err", bus.dup_err, 1'b0);
    end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    check("post_rst_out_valid", bus.out_valid, 1'b0);

    // 2: in-order frame
    send_frame(ord_inc, 32'h0);
    check("latency_out_valid", bus.out_valid, 1'b1);
    expect_ramp();
    wait_idle();

    // 3: scrambled pair order
    send_frame(ord_scr, 32'h0);
    expect_ramp();
    wait_idle();

    // 4: backpressure on output cycles 3..5
    send_frame(ord_inc, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data", bus.out_data, 32'd3);
      check("stall_idx", bus.out_idx, 32'd3);
    end
    bus.out_ready = 1'b1;
    nl = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_last) nl++;
    end
    check("stall_last_count", nl, 32'd1);
    wait_idle();

    // 5: ping-pong, both banks full, then drain
    bus.out_ready = 1'b0;
    send_frame(ord_inc, 32'h0000_0100);
    send_frame(ord_scr, 32'h0000_0200);
    bus.in_valid = 1'b1;
    bus.in_pair  = 3'd0;
    #1;
    check("both_full_in_ready", bus.in_ready, 1'b0);
    check("both_full_data_A0", bus.out_data, 32'h0000_0100);
    last_cyc = -1;
    bus.out_ready = 1'b1;
    send_pair(0, 32'h0000_0300 + 32'(rev4(0)), 32'h0000_0300 + 32'(rev4(0) + 8));
    check("c_accept_after_a_last", acc_cyc, last_cyc + 1);
    for (int k = 1; k < 8; k++)
      send_pair(k, 32'h0000_0300 + 32'(rev4(2 * k)), 32'h0000_0300 + 32'(rev4(2 * k) + 8));
    wait_idle();

    // 6: duplicate pair, then reset mid-drain
    send_pair(2, 32'hAAAA_0000, 32'h0000_100A);
    send_pair(2, 32'hBBBB_0000, 32'h0000_100A);
    @(negedge clk);
    check("dup_pulse", bus.dup_err, 1'b1);
    @(negedge clk);
    check("dup_pulse_end", bus.dup_err, 1'b0);
    for (int k = 0; k < 8; k++)
      if (k != 2)
        send_pair(k, 32'h0000_1000 + 32'(rev4(2 * k)), 32'h0000_1000 + 32'(rev4(2 * k) + 8));
    seen2 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.out_valid && bus.out_idx == 4'd2 && !seen2) begin
        seen2 = 1'b1;
        check("dup_last_wins", bus.out_data, 32'hBBBB_0000);
      end
      if (bus.out_valid && bus.out_idx == 4'd6) break;
      @(negedge clk);
    end
    check("dup_idx2_seen", seen2, 1'b1);
    check("reset_point_idx", bus.out_idx, 32'd6);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", bus.out_valid, 1'b0);
    check("midreset_out_data", bus.out_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    send_frame(ord_inc, 32'h0);
    expect_ramp();
    wait_idle();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
